// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Covers default widths, the zero-register constant and requester IDs.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } reqId_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie,
// and it moves to the loser only when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic rrPtr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rrPtr <= 1'b0;
    else if (grant[0]) rrPtr <= 1'b1;
    else if (grant[1]) rrPtr <= 1'b0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU and load/store
// writeback paths, using one holding slot each and a registered output stage.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  output logic                     WE,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     grant_id,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int NREG = 1 << ADDR_W;

  logic              slot0Full, slot1Full;
  logic [ADDR_W-1:0] slot0Addr, slot1Addr;
  logic [DATA_W-1:0] slot0Data, slot1Data;
  logic              live0, live1;
  logic [ADDR_W-1:0] cand0Addr, cand1Addr;
  logic [DATA_W-1:0] cand0Data, cand1Data;
  logic [1:0]        cand;
  logic [1:0]        grant;

  assign req0_ready = !slot0Full;
  assign req1_ready = !slot1Full;

  // A live write to the zero register is accepted but never becomes a candidate.
  assign live0 = req0_valid && req0_ready && (req0_addr != ADDR_W'(ZERO_REG));
  assign live1 = req1_valid && req1_ready && (req1_addr != ADDR_W'(ZERO_REG));

  assign cand      = {slot1Full | live1, slot0Full | live0};
  assign cand0Addr = slot0Full ? slot0Addr : req0_addr;
  assign cand0Data = slot0Full ? slot0Data : req0_data;
  assign cand1Addr = slot1Full ? slot1Addr : req1_addr;
  assign cand1Data = slot1Full ? slot1Data : req1_data;

  rr_arbiter2 u_arb (
    .clk   (CLK),
    .rst_n (RST_n),
    .req   (cand),
    .grant (grant)
  );

  // Output stage: address, data and owner hold their values when idle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      WE        <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      grant_id  <= REQ_ALU;
    end else if (grant[0]) begin
      WE        <= 1'b1;
      WriteReg  <= cand0Addr;
      WriteData <= cand0Data;
      grant_id  <= REQ_ALU;
    end else if (grant[1]) begin
      WE        <= 1'b1;
      WriteReg  <= cand1Addr;
      WriteData <= cand1Data;
      grant_id  <= REQ_LSU;
    end else begin
      WE        <= 1'b0;
    end
  end

  // A slot is only loaded from a live write that lost arbitration, so it is always empty then.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      slot0Full <= 1'b0;
      slot0Addr <= '0;
      slot0Data <= '0;
    end else if (grant[0]) begin
      slot0Full <= 1'b0;
    end else if (live0) begin
      slot0Full <= 1'b1;
      slot0Addr <= req0_addr;
      slot0Data <= req0_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      slot1Full <= 1'b0;
      slot1Addr <= '0;
      slot1Data <= '0;
    end else if (grant[1]) begin
      slot1Full <= 1'b0;
    end else if (live1) begin
      slot1Full <= 1'b1;
      slot1Addr <= req1_addr;
      slot1Data <= req1_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREG; i++) begin
      pending[i] = (slot0Full && (slot0Addr == ADDR_W'(i))) ||
                   (slot1Full && (slot1Addr == ADDR_W'(i))) ||
                   (WE && (WriteReg == ADDR_W'(i)));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scoreboard-driven write monitor
// and a behavioural register file fed by the DUT's write port.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        gid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        WE;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        grant_id;
  logic [31:0] pending;

  wr_t         expQ[$];
  logic [31:0] rfModel [32] = '{default: '0};
  int          total = 0;
  int          bad = 0;
  int          runLen = 0;
  int          maxRun = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .WE         (WE),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .grant_id   (grant_id),
    .pending    (pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input logic gid, input logic [4:0] addr, input logic [31:0] data);
    wr_t e;
    e.gid  = gid;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Monitor: every WE cycle must match the next expected write, and updates the register model.
  always @(negedge CLK) begin
    if (RST_n && WE) begin
      runLen++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got reg=%0d data=%0h gid=%0d expected no write",
                 WriteReg, WriteData, grant_id);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        chk("wr_gid", 64'(grant_id), 64'(e.gid));
        chk("wr_reg", 64'(WriteReg), 64'(e.addr));
        chk("wr_data", 64'(WriteData), 64'(e.data));
      end
      rfModel[WriteReg] = WriteData;
    end else begin
      if (runLen > maxRun) maxRun = runLen;
      runLen = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, i1;
    logic a0, a1;
    RST_n = 1'b0;
    idle();
    req0_addr = '0; req0_data = '0;
    req1_addr = '0; req1_data = '0;
    #12;
    chk("rst_we", 64'(WE), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_ready0", 64'(req0_ready), 64'(1));
    chk("rst_ready1", 64'(req1_ready), 64'(1));
    RST_n = 1'b1;

    // Single requester, empty slot path
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_00AA;
    expect_wr(1'b0, 5'd3, 32'hAA);
    step(); idle();
    chk("single_we", 64'(WE), 64'(1));
    chk("single_reg", 64'(WriteReg), 64'(3));
    chk("single_gid", 64'(grant_id), 64'(0));
    chk("single_pend", 64'(pending), 64'(32'h0000_0008));
    @(negedge CLK); #1;
    chk("single_rf3", 64'(rfModel[3]), 64'(32'hAA));
    step();
    chk("single_pend_clr", 64'(pending), 64'(0));
    chk("single_we_clr", 64'(WE), 64'(0));

    // Single req1 write moves rr_ptr back to 0
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    expect_wr(1'b1, 5'd9, 32'h99);
    step(); idle(); step();

    // Contention with rr_ptr=0
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h22;
    expect_wr(1'b0, 5'd5, 32'h11);
    expect_wr(1'b1, 5'd6, 32'h22);
    step(); idle();
    chk("cont_ready1_lo", 64'(req1_ready), 64'(0));
    chk("cont_ready0", 64'(req0_ready), 64'(1));
    chk("cont_pend_n", 64'(pending), 64'(32'h0000_0060));
    step();
    chk("cont_ready1_hi", 64'(req1_ready), 64'(1));
    chk("cont_pend_n1", 64'(pending), 64'(32'h0000_0040));
    chk("cont_we_n1", 64'(WE), 64'(1));
    step();
    chk("cont_pend_clr", 64'(pending), 64'(0));
    chk("cont_we_clr", 64'(WE), 64'(0));

    // Address 0 write is accepted and dropped
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    chk("a0_ready", 64'(req1_ready), 64'(1));
    step(); idle();
    chk("a0_we", 64'(WE), 64'(0));
    chk("a0_pend", 64'(pending), 64'(0));
    chk("a0_ready_after", 64'(req1_ready), 64'(1));
    step();
    chk("a0_we2", 64'(WE), 64'(0));
    chk("a0_rf0", 64'(rfModel[0]), 64'(0));

    // Single req0 write sets rr_ptr=1, then same-address contention
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    expect_wr(1'b0, 5'd4, 32'h44);
    step(); idle(); step();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h2;
    expect_wr(1'b1, 5'd7, 32'h2);
    expect_wr(1'b0, 5'd7, 32'h1);
    step(); idle();
    chk("same_gid_first", 64'(grant_id), 64'(1));
    chk("same_pend", 64'(pending), 64'(32'h0000_0080));
    step();
    chk("same_gid_second", 64'(grant_id), 64'(0));
    @(negedge CLK); #1;
    chk("same_rf7", 64'(rfModel[7]), 64'(32'h1));
    step();

    // Single req1 write sets rr_ptr=0, then both stream 8 writes each
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hA0;
    expect_wr(1'b1, 5'd10, 32'hA0);
    step(); idle(); step(); step();
    maxRun = 0;
    for (int k = 0; k < 8; k++) begin
      expect_wr(1'b0, 5'(k + 1), 32'h100 + 32'(k));
      expect_wr(1'b1, 5'(k + 16), 32'h200 + 32'(k));
    end
    i0 = 0; i1 = 0;
    for (int c = 0; c < 40 && (i0 < 8 || i1 < 8); c++) begin
      req0_valid = (i0 < 8); req0_addr = 5'(i0 + 1);  req0_data = 32'h100 + 32'(i0);
      req1_valid = (i1 < 8); req1_addr = 5'(i1 + 16); req1_data = 32'h200 + 32'(i1);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
    end
    idle();
    chk("stream_accepted", 64'(i0 + i1), 64'(16));
    step(); step(); step(); step();
    chk("stream_b2b_we", 64'(maxRun), 64'(16));

    // Reset mid-burst with slot1 full
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'hD;
    step(); idle();
    chk("rst_pre_slot1", 64'(req1_ready), 64'(0));
    #2;
    RST_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(WE), 64'(0));
    chk("rst_mid_pend", 64'(pending), 64'(0));
    chk("rst_mid_ready0", 64'(req0_ready), 64'(1));
    chk("rst_mid_ready1", 64'(req1_ready), 64'(1));
    chk("rst_mid_reg", 64'(WriteReg), 64'(0));
    chk("rst_mid_data", 64'(WriteData), 64'(0));
    chk("rst_mid_gid", 64'(grant_id), 64'(0));
    @(posedge CLK); #2;
    RST_n = 1'b1;
    step(); step(); step();
    chk("rst_post_pend", 64'(pending), 64'(0));
    chk("rst_post_we", 64'(WE), 64'(0));
    chk("rst_post_rf13", 64'(rfModel[13]), 64'(0));

    chk("queue_empty", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
